// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Multi-cycle MEM stage for the OpenMIPS pipeline. Drives a
//            req/ack data bus with arbitrary wait states, stalls the pipeline
//            while an access is outstanding, steers byte lanes for either
//            endianness and flags misaligned addresses and bus timeouts.
// Optional : MEM_LLSC_EN - when defined, LL/SC use an address-checked link
//            bit. When undefined, LL acts as LW and SC as SW returning 1.
// Ports    : clk, rst (async, active-low)
//            req_valid_i, aluop_i, mem_addr_i, reg2_i, wd_i, wreg_i, wdata_i
//                                        - EX/MEM side
//            flush_i, llbit_clr_i        - pipeline control
//            wd_o, wreg_o, wdata_o, done_o
//                                        - MEM/WB side
//            stallreq_o                  - stall request to ctrl
//            excp_adel_o, excp_ades_o, bus_err_o, bad_addr_o
//                                        - exception reporting
//            bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
//            bus_ack_i, bus_rdata_i      - data bus
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter bit BIG_ENDIAN = 1'b1,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    input  logic              llbit_clr_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o,
    output logic              done_o,
    output logic              stallreq_o,
    output logic              excp_adel_o,
    output logic              excp_ades_o,
    output logic              bus_err_o,
    output logic [ADDR_W-1:0] bad_addr_o,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [3:0]        bus_sel_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i
);

    // OpenMIPS ALU operation codes for memory instructions
    localparam logic [7:0] c_EXE_LB_OP  = 8'b1110_0000;
    localparam logic [7:0] c_EXE_LBU_OP = 8'b1110_0100;
    localparam logic [7:0] c_EXE_LH_OP  = 8'b1110_0001;
    localparam logic [7:0] c_EXE_LHU_OP = 8'b1110_0101;
    localparam logic [7:0] c_EXE_LW_OP  = 8'b1110_0011;
    localparam logic [7:0] c_EXE_LL_OP  = 8'b1111_0000;
    localparam logic [7:0] c_EXE_SB_OP  = 8'b1110_1000;
    localparam logic [7:0] c_EXE_SH_OP  = 8'b1110_1001;
    localparam logic [7:0] c_EXE_SW_OP  = 8'b1110_1011;
    localparam logic [7:0] c_EXE_SC_OP  = 8'b1111_1000;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic mem;
        logic load;
        logic byte_sz;
        logic half_sz;
        logic sext;
        logic ll;
        logic sc;
    } op_info_t;

    function automatic op_info_t decode_op(input logic [7:0] op);
        op_info_t d;
        d = '0;
        case (op)
            c_EXE_LB_OP:  begin d.mem = 1'b1; d.load = 1'b1; d.byte_sz = 1'b1; d.sext = 1'b1; end
            c_EXE_LBU_OP: begin d.mem = 1'b1; d.load = 1'b1; d.byte_sz = 1'b1; end
            c_EXE_LH_OP:  begin d.mem = 1'b1; d.load = 1'b1; d.half_sz = 1'b1; d.sext = 1'b1; end
            c_EXE_LHU_OP: begin d.mem = 1'b1; d.load = 1'b1; d.half_sz = 1'b1; end
            c_EXE_LW_OP:  begin d.mem = 1'b1; d.load = 1'b1; end
            c_EXE_LL_OP:  begin d.mem = 1'b1; d.load = 1'b1; d.ll = 1'b1; end
            c_EXE_SB_OP:  begin d.mem = 1'b1; d.byte_sz = 1'b1; end
            c_EXE_SH_OP:  begin d.mem = 1'b1; d.half_sz = 1'b1; end
            c_EXE_SW_OP:  begin d.mem = 1'b1; end
            c_EXE_SC_OP:  begin d.mem = 1'b1; d.sc = 1'b1; end
            default:      d = '0;
        endcase
        return d;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [7:0]         op_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [31:0]        sdata_q;
    logic [4:0]         wd_q;
    logic               wreg_q;
    logic [31:0]        result_q;
    logic               adel_q;
    logic               ades_q;
    logic               berr_q;
    logic [ADDR_W-1:0]  badaddr_q;
    logic [c_CNT_W-1:0] cnt_q;

    op_info_t    w_in;
    op_info_t    w_cur;
    logic        w_accept;
    logic        w_misaligned;
    logic        w_sc_fail;
    logic        w_timeout;
    logic        w_ack;
    logic [1:0]  w_lane;
    logic        w_hi_half;
    logic [7:0]  w_rbyte;
    logic [15:0] w_rhalf;
    logic [31:0] w_load_data;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;

    assign w_in  = decode_op(aluop_i);
    assign w_cur = decode_op(op_q);

    // A flushed instruction is never accepted.
    assign w_accept = (state_q == c_ST_IDLE) && req_valid_i && w_in.mem && !flush_i;

    assign w_misaligned = (w_in.half_sz && mem_addr_i[0]) ||
                          (!w_in.byte_sz && !w_in.half_sz && (mem_addr_i[1:0] != 2'b00));

    assign w_timeout = (cnt_q == c_CNT_LAST);
    assign w_ack     = (state_q == c_ST_REQ) && bus_ack_i && !flush_i;

    // Physical byte lane for the latched address. Big-endian places offset 0
    // in the most significant lane; little-endian mirrors that.
    assign w_lane    = BIG_ENDIAN ? (2'd3 - addr_q[1:0]) : addr_q[1:0];
    assign w_hi_half = BIG_ENDIAN ? ~addr_q[1] : addr_q[1];

    assign w_rbyte = bus_rdata_i[{w_lane, 3'b000} +: 8];
    assign w_rhalf = w_hi_half ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        w_load_data = bus_rdata_i;
        if (w_cur.byte_sz) begin
            w_load_data = {{24{w_cur.sext & w_rbyte[7]}}, w_rbyte};
        end else if (w_cur.half_sz) begin
            w_load_data = {{16{w_cur.sext & w_rhalf[15]}}, w_rhalf};
        end
    end

    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = sdata_q;
        if (w_cur.byte_sz) begin
            w_sel   = 4'b0001 << w_lane;
            w_wdata = {4{sdata_q[7:0]}};
        end else if (w_cur.half_sz) begin
            w_sel   = w_hi_half ? 4'b1100 : 4'b0011;
            w_wdata = {2{sdata_q[15:0]}};
        end
    end

`ifdef MEM_LLSC_EN
    logic              llbit_q, llbit_d;
    logic [ADDR_W-3:0] lladdr_q, lladdr_d;

    // SC proceeds to the bus only while the link for its word is intact.
    assign w_sc_fail = w_in.sc && !(llbit_q && (lladdr_q == mem_addr_i[ADDR_W-1:2]));

    always_comb begin
        llbit_d  = llbit_q;
        lladdr_d = lladdr_q;
        if (w_ack) begin
            if (w_cur.ll) begin
                llbit_d  = 1'b1;
                lladdr_d = addr_q[ADDR_W-1:2];
            end else if (w_cur.sc) begin
                llbit_d = 1'b0;
            end else if (!w_cur.load && (addr_q[ADDR_W-1:2] == lladdr_q)) begin
                // an ordinary store to the linked word breaks the link
                llbit_d = 1'b0;
            end
        end
        if (llbit_clr_i || flush_i) begin
            llbit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            llbit_q  <= 1'b0;
            lladdr_q <= '0;
        end else begin
            llbit_q  <= llbit_d;
            lladdr_q <= lladdr_d;
        end
    end
`else
    logic w_unused_llclr;

    assign w_sc_fail      = 1'b0;
    assign w_unused_llclr = llbit_clr_i;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (w_accept) begin
                    state_d = (w_misaligned || w_sc_fail) ? c_ST_DONE : c_ST_REQ;
                end
            end
            c_ST_REQ: begin
                // an ack in the last allowed cycle wins over the timeout
                if (bus_ack_i || w_timeout) begin
                    state_d = c_ST_DONE;
                end
            end
            c_ST_DONE: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
        if (flush_i) begin
            state_d = c_ST_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        done_o      = 1'b0;
        stallreq_o  = 1'b0;
        excp_adel_o = 1'b0;
        excp_ades_o = 1'b0;
        bus_err_o   = 1'b0;
        bad_addr_o  = '0;
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_addr_o  = '0;
        bus_sel_o   = '0;
        bus_wdata_o = '0;
        case (state_q)
            c_ST_IDLE: begin
                if (req_valid_i && w_in.mem) begin
                    stallreq_o = !flush_i;
                end else begin
                    // non-memory instructions flow straight through
                    wd_o    = wd_i;
                    wreg_o  = wreg_i;
                    wdata_o = wdata_i;
                    done_o  = req_valid_i && !flush_i;
                end
            end
            c_ST_REQ: begin
                stallreq_o  = !flush_i;
                bus_req_o   = !flush_i;
                bus_we_o    = !w_cur.load;
                bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
                bus_sel_o   = w_sel;
                bus_wdata_o = w_wdata;
            end
            c_ST_DONE: begin
                if (!flush_i) begin
                    done_o      = 1'b1;
                    wd_o        = wd_q;
                    wreg_o      = wreg_q;
                    wdata_o     = result_q;
                    excp_adel_o = adel_q;
                    excp_ades_o = ades_q;
                    bus_err_o   = berr_q;
                    bad_addr_o  = badaddr_q;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q      <= '0;
            addr_q    <= '0;
            sdata_q   <= '0;
            wd_q      <= '0;
            wreg_q    <= 1'b0;
            result_q  <= '0;
            adel_q    <= 1'b0;
            ades_q    <= 1'b0;
            berr_q    <= 1'b0;
            badaddr_q <= '0;
            cnt_q     <= '0;
        end else if (w_accept) begin
            op_q      <= aluop_i;
            addr_q    <= mem_addr_i;
            sdata_q   <= reg2_i;
            wd_q      <= wd_i;
            wreg_q    <= wreg_i && !w_misaligned;
            // stores report the ALU result; a failed SC reports 0
            result_q  <= w_sc_fail ? 32'd0 : wdata_i;
            adel_q    <= w_misaligned && w_in.load;
            ades_q    <= w_misaligned && !w_in.load;
            berr_q    <= 1'b0;
            badaddr_q <= w_misaligned ? mem_addr_i : '0;
            cnt_q     <= '0;
        end else if ((state_q == c_ST_REQ) && !flush_i) begin
            if (bus_ack_i) begin
                if (w_cur.load) begin
                    result_q <= w_load_data;
                end else if (w_cur.sc) begin
                    result_q <= 32'd1;
                end
            end else if (w_timeout) begin
                berr_q    <= 1'b1;
                wreg_q    <= 1'b0;
                badaddr_q <= addr_q;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Self-checking bench for mem_access_unit. Two instances (big- and
//            little-endian) share stimulus; a byte-level memory-order model
//            predicts bus traffic, timing and results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;

    localparam int TIMEOUT = 4;

    localparam logic [7:0] c_OP_LB  = 8'b1110_0000;
    localparam logic [7:0] c_OP_LBU = 8'b1110_0100;
    localparam logic [7:0] c_OP_LH  = 8'b1110_0001;
    localparam logic [7:0] c_OP_LHU = 8'b1110_0101;
    localparam logic [7:0] c_OP_LW  = 8'b1110_0011;
    localparam logic [7:0] c_OP_LL  = 8'b1111_0000;
    localparam logic [7:0] c_OP_SB  = 8'b1110_1000;
    localparam logic [7:0] c_OP_SH  = 8'b1110_1001;
    localparam logic [7:0] c_OP_SW  = 8'b1110_1011;
    localparam logic [7:0] c_OP_SC  = 8'b1111_1000;
    localparam logic [7:0] c_OP_ADD = 8'b0010_0000;

`ifdef MEM_LLSC_EN
    localparam bit c_LLSC = 1'b1;
`else
    localparam bit c_LLSC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r_req_valid = 1'b0;
    logic [7:0]  r_aluop = '0;
    logic [31:0] r_addr = '0;
    logic [31:0] r_reg2 = '0;
    logic [4:0]  r_wd = '0;
    logic        r_wreg = 1'b0;
    logic [31:0] r_wdata = '0;
    logic        r_flush = 1'b0;
    logic        r_llclr = 1'b0;
    logic        r_ack = 1'b0;
    logic [31:0] r_rdata = '0;

    logic [4:0]  w_wd_be, w_wd_le;
    logic        w_wreg_be, w_wreg_le;
    logic [31:0] w_wdata_be, w_wdata_le;
    logic        w_done_be, w_done_le, w_stall_be, w_stall_le;
    logic        w_adel_be, w_adel_le, w_ades_be, w_ades_le, w_berr_be, w_berr_le;
    logic [31:0] w_bad_be, w_bad_le;
    logic        w_breq_be, w_breq_le, w_bwe_be, w_bwe_le;
    logic [31:0] w_baddr_be, w_baddr_le, w_bwd_be, w_bwd_le;
    logic [3:0]  w_bsel_be, w_bsel_le;

    int n_checks = 0;
    int n_errors = 0;

    // expectation of the transaction in flight
    int          e_off, e_n;
    bit          e_load, e_sext, e_sc, e_mis, e_scfail, e_tmo;
    logic [31:0] e_addr, e_r2, e_rd, e_alu;
    logic [4:0]  e_wd;
    logic        e_wreg;

    // reference link state
    bit          m_llbit = 1'b0;
    logic [29:0] m_lladdr = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b1), .TIMEOUT(TIMEOUT)) u_dut_be (
        .clk(clk), .rst(rst), .req_valid_i(r_req_valid), .aluop_i(r_aluop),
        .mem_addr_i(r_addr), .reg2_i(r_reg2), .wd_i(r_wd), .wreg_i(r_wreg),
        .wdata_i(r_wdata), .flush_i(r_flush), .llbit_clr_i(r_llclr),
        .wd_o(w_wd_be), .wreg_o(w_wreg_be), .wdata_o(w_wdata_be), .done_o(w_done_be),
        .stallreq_o(w_stall_be), .excp_adel_o(w_adel_be), .excp_ades_o(w_ades_be),
        .bus_err_o(w_berr_be), .bad_addr_o(w_bad_be), .bus_req_o(w_breq_be),
        .bus_we_o(w_bwe_be), .bus_addr_o(w_baddr_be), .bus_sel_o(w_bsel_be),
        .bus_wdata_o(w_bwd_be), .bus_ack_i(r_ack), .bus_rdata_i(r_rdata)
    );

    mem_access_unit #(.ADDR_W(32), .BIG_ENDIAN(1'b0), .TIMEOUT(TIMEOUT)) u_dut_le (
        .clk(clk), .rst(rst), .req_valid_i(r_req_valid), .aluop_i(r_aluop),
        .mem_addr_i(r_addr), .reg2_i(r_reg2), .wd_i(r_wd), .wreg_i(r_wreg),
        .wdata_i(r_wdata), .flush_i(r_flush), .llbit_clr_i(r_llclr),
        .wd_o(w_wd_le), .wreg_o(w_wreg_le), .wdata_o(w_wdata_le), .done_o(w_done_le),
        .stallreq_o(w_stall_le), .excp_adel_o(w_adel_le), .excp_ades_o(w_ades_le),
        .bus_err_o(w_berr_le), .bad_addr_o(w_bad_le), .bus_req_o(w_breq_le),
        .bus_we_o(w_bwe_le), .bus_addr_o(w_baddr_le), .bus_sel_o(w_bsel_le),
        .bus_wdata_o(w_bwd_le), .bus_ack_i(r_ack), .bus_rdata_i(r_rdata)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (memory-order view) ----------------
    function automatic int lane_of(input int idx, input bit be);
        return be ? (3 - idx) : idx;
    endfunction

    function automatic logic [7:0] byte_at(input logic [31:0] w, input int idx, input bit be);
        return w[8*lane_of(idx, be) +: 8];
    endfunction

    function automatic logic [3:0] exp_sel(input int off, input int n, input bit be);
        logic [3:0] m;
        m = '0;
        for (int i = off; i < off + n; i++) m[lane_of(i, be)] = 1'b1;
        return m;
    endfunction

    // big-endian: lowest address is most significant; little-endian: highest
    function automatic logic [31:0] exp_load(input logic [31:0] w, input int off, input int n,
                                             input bit sext, input bit be);
        logic [31:0] v;
        int idx;
        v = '0;
        for (int i = 0; i < n; i++) begin
            idx = be ? (off + i) : (off + n - 1 - i);
            v = (v << 8) | {24'd0, byte_at(w, idx, be)};
        end
        if (sext && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (sext && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    function automatic logic [31:0] exp_bus_wdata(input logic [31:0] r2, input int n);
        if (n == 1) return {4{r2[7:0]}};
        if (n == 2) return {2{r2[15:0]}};
        return r2;
    endfunction

    task automatic check_bus(input bit be, input logic we, input logic [31:0] a,
                             input logic [3:0] sel, input logic [31:0] wd);
        string p;
        p = be ? "be" : "le";
        check_value({p, "_bus_we"}, 32'(we), 32'(!e_load));
        check_value({p, "_bus_addr"}, a, {e_addr[31:2], 2'b00});
        check_value({p, "_bus_sel"}, 32'(sel), 32'(exp_sel(e_off, e_n, be)));
        if (!e_load) check_value({p, "_bus_wdata"}, wd, exp_bus_wdata(e_r2, e_n));
    endtask

    task automatic check_done(input bit be, input logic dn, input logic [4:0] wdo, input logic wr,
                              input logic [31:0] wdat, input logic adel, input logic ades,
                              input logic berr, input logic [31:0] bad);
        string p;
        logic [31:0] ev;
        p = be ? "be" : "le";
        check_value({p, "_done"}, 32'(dn), 32'd1);
        check_value({p, "_wd"}, 32'(wdo), 32'(e_wd));
        check_value({p, "_wreg"}, 32'(wr), 32'((e_mis || e_tmo) ? 1'b0 : e_wreg));
        check_value({p, "_adel"}, 32'(adel), 32'(e_mis && e_load));
        check_value({p, "_ades"}, 32'(ades), 32'(e_mis && !e_load));
        check_value({p, "_bus_err"}, 32'(berr), 32'(e_tmo));
        if (e_mis || e_tmo) begin
            check_value({p, "_bad_addr"}, bad, e_addr);
        end else begin
            if (e_load)        ev = exp_load(e_rd, e_off, e_n, e_sext, be);
            else if (e_sc)     ev = e_scfail ? 32'd0 : 32'd1;
            else               ev = e_alu;
            check_value({p, "_wdata"}, wdat, ev);
        end
    endtask

    // One instruction through the stage. waits >= TIMEOUT means no ack.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] r2,
                          input logic [31:0] rd, input int waits);
        bit mem;
        int exp_done, exp_req, nreq_be, nreq_le, got_done;
        mem = 1'b1; e_load = 1'b0; e_sext = 1'b0; e_sc = 1'b0; e_n = 4;
        case (op)
            c_OP_LB:  begin e_load = 1; e_sext = 1; e_n = 1; end
            c_OP_LBU: begin e_load = 1; e_n = 1; end
            c_OP_LH:  begin e_load = 1; e_sext = 1; e_n = 2; end
            c_OP_LHU: begin e_load = 1; e_n = 2; end
            c_OP_LW, c_OP_LL: e_load = 1;
            c_OP_SB:  e_n = 1;
            c_OP_SH:  e_n = 2;
            c_OP_SW:  ;
            c_OP_SC:  e_sc = 1;
            default:  mem = 1'b0;
        endcase
        e_addr = a; e_r2 = r2; e_rd = rd; e_off = int'(a[1:0]);
        e_wd = 5'($urandom); e_wreg = 1'($urandom); e_alu = $urandom;

        @(posedge clk); #1;
        r_req_valid = 1'b1; r_aluop = op; r_addr = a; r_reg2 = r2;
        r_wd = e_wd; r_wreg = e_wreg; r_wdata = e_alu; r_ack = 1'b0;
        #1;
        if (!mem) begin
            check_value("nonmem_done_be", 32'(w_done_be), 32'd1);
            check_value("nonmem_wdata_be", w_wdata_be, e_alu);
            check_value("nonmem_wd_le", 32'(w_wd_le), 32'(e_wd));
            check_value("nonmem_stall_le", 32'(w_stall_le), 32'd0);
            return;
        end
        check_value("accept_stall_be", 32'(w_stall_be), 32'd1);
        check_value("accept_done_le", 32'(w_done_le), 32'd0);

        e_mis    = (e_n == 2 && a[0]) || (e_n == 4 && a[1:0] != 2'b00);
        e_scfail = e_sc && c_LLSC && !e_mis && !(m_llbit && m_lladdr == a[31:2]);
        e_tmo    = !e_mis && !e_scfail && (waits >= TIMEOUT);
        if (e_mis || e_scfail) begin exp_done = 1; exp_req = 0; end
        else if (!e_tmo)       begin exp_done = waits + 2; exp_req = waits + 1; end
        else                   begin exp_done = TIMEOUT + 1; exp_req = TIMEOUT; end

        nreq_be = 0; nreq_le = 0; got_done = 0;
        for (int k = 1; k <= 12 && got_done == 0; k++) begin
            @(posedge clk); #1;
            r_ack = 1'b0; r_rdata = $urandom;
            #1;
            if (w_breq_le) begin
                nreq_le++;
                check_bus(1'b0, w_bwe_le, w_baddr_le, w_bsel_le, w_bwd_le);
            end
            if (w_breq_be) begin
                nreq_be++;
                check_bus(1'b1, w_bwe_be, w_baddr_be, w_bsel_be, w_bwd_be);
                if (nreq_be == waits + 1) begin
                    r_ack = 1'b1; r_rdata = rd;
                end
            end
            if (w_done_be) begin
                got_done = k;
                check_value("done_stall_be", 32'(w_stall_be), 32'd0);
                check_done(1'b1, w_done_be, w_wd_be, w_wreg_be, w_wdata_be,
                           w_adel_be, w_ades_be, w_berr_be, w_bad_be);
                check_done(1'b0, w_done_le, w_wd_le, w_wreg_le, w_wdata_le,
                           w_adel_le, w_ades_le, w_berr_le, w_bad_le);
            end
        end
        check_value("done_cycle", 32'(got_done), 32'(exp_done));
        check_value("req_cycles_be", 32'(nreq_be), 32'(exp_req));
        check_value("req_cycles_le", 32'(nreq_le), 32'(exp_req));

        if (c_LLSC && !e_mis && !e_scfail && !e_tmo) begin
            if (op == c_OP_LL) begin
                m_llbit = 1'b1; m_lladdr = a[31:2];
            end else if (e_sc) begin
                m_llbit = 1'b0;
            end else if (!e_load && a[31:2] == m_lladdr) begin
                m_llbit = 1'b0;
            end
        end
    endtask

    task automatic pulse_llclr();
        @(posedge clk); #1;
        r_req_valid = 1'b0; r_llclr = 1'b1;
        @(posedge clk); #1;
        r_llclr = 1'b0;
        m_llbit = 1'b0;
    endtask

    task automatic run_flush();
        @(posedge clk); #1;
        r_req_valid = 1'b1; r_aluop = c_OP_LW; r_addr = 32'h80; r_wreg = 1'b1;
        @(posedge clk); #1;
        r_req_valid = 1'b0; r_flush = 1'b1; r_ack = 1'b1; r_rdata = 32'hDEADBEEF;
        #1;
        check_value("flush_req_be", 32'(w_breq_be), 32'd0);
        check_value("flush_req_le", 32'(w_breq_le), 32'd0);
        check_value("flush_done_be", 32'(w_done_be), 32'd0);
        @(posedge clk); #1;
        r_flush = 1'b0; r_ack = 1'b0;
        #1;
        check_value("post_flush_done_be", 32'(w_done_be), 32'd0);
        check_value("post_flush_req_be", 32'(w_breq_be), 32'd0);
        check_value("post_flush_stall_le", 32'(w_stall_le), 32'd0);
        m_llbit = 1'b0;
    endtask

    task automatic run_async_reset();
        @(posedge clk); #1;
        r_req_valid = 1'b1; r_aluop = c_OP_LW; r_addr = 32'h84;
        @(posedge clk); #2;
        check_value("pre_rst_req_be", 32'(w_breq_be), 32'd1);
        rst = 1'b0; r_req_valid = 1'b0;
        #1;
        check_value("async_rst_req_be", 32'(w_breq_be), 32'd0);
        check_value("async_rst_req_le", 32'(w_breq_le), 32'd0);
        check_value("async_rst_stall_be", 32'(w_stall_be), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        m_llbit = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ops [10];
        logic [7:0] op;
        logic [31:0] a;
        int sel, off;
        ops = '{c_OP_LB, c_OP_LBU, c_OP_LH, c_OP_LHU, c_OP_LW,
                c_OP_LL, c_OP_SB, c_OP_SH, c_OP_SW, c_OP_SC};

        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_bus_req", 32'(w_breq_be), 32'd0);
        check_value("rst_stall", 32'(w_stall_le), 32'd0);
        check_value("rst_done", 32'(w_done_be), 32'd0);
        check_value("rst_wdata", w_wdata_le, 32'd0);
        check_value("rst_bus_err", 32'(w_berr_be), 32'd0);
        rst = 1'b1;

        // directed cases
        run_op(c_OP_LB, 32'h103, 32'h0, 32'h0000_00F0, 2);
        run_op(c_OP_SH, 32'h202, 32'h1234_ABCD, 32'h0, 0);
        run_op(c_OP_LW, 32'h101, 32'h0, 32'h0, 0);
        run_op(c_OP_LH, 32'h103, 32'h0, 32'h0, 0);
        run_op(c_OP_SW, 32'h10, 32'hCAFE_F00D, 32'h0, 9);
        run_op(c_OP_LHU, 32'h22, 32'h0, 32'h8001_7FFE, TIMEOUT - 1);
        run_op(c_OP_ADD, 32'h0, 32'h0, 32'h0, 0);
        run_op(c_OP_LL, 32'h40, 32'h0, 32'h1111_2222, 1);
        run_op(c_OP_SC, 32'h40, 32'h5555_AAAA, 32'h0, 0);
        run_op(c_OP_SC, 32'h40, 32'h5555_AAAA, 32'h0, 0);
        run_op(c_OP_LL, 32'h48, 32'h0, 32'h0, 0);
        pulse_llclr();
        run_op(c_OP_SC, 32'h48, 32'h1, 32'h0, 0);
        run_op(c_OP_LL, 32'h4C, 32'h0, 32'h0, 0);
        run_op(c_OP_SB, 32'h4E, 32'h77, 32'h0, 0);
        run_op(c_OP_SC, 32'h4C, 32'h2, 32'h0, 0);
        run_flush();
        run_async_reset();

        // randomized traffic over a few words so LL/SC pairs collide
        for (int t = 0; t < 80; t++) begin
            sel = $urandom_range(0, 10);
            op  = (sel == 10) ? c_OP_ADD : ops[sel];
            off = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 0) begin
                if (op == c_OP_LH || op == c_OP_LHU || op == c_OP_SH) off = off & 2;
                else if (op != c_OP_LB && op != c_OP_LBU && op != c_OP_SB) off = 0;
            end
            a = 32'h40 + 32'($urandom_range(0, 3) * 4 + off);
            if ($urandom_range(0, 9) == 0) pulse_llclr();
            run_op(op, a, $urandom, $urandom, $urandom_range(0, 5));
        end

        @(posedge clk); #1;
        r_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle memory-access stage for the OpenMIPS pipeline, replacing the single-cycle combinational MEM logic. It sits between the EX/MEM and MEM/WB registers and drives a request/acknowledge data bus with arbitrary wait states. It raises a pipeline stall while an access is outstanding and performs byte-lane steering for either endianness. It also flags misaligned addresses and bus timeouts, and optionally implements LL/SC with address-checked link state.

## Interface
- ADDR_W, 32, data-bus address width (≥ 3); data width fixed at 32
- BIG_ENDIAN, 1, 1: offset 00 maps to lane [31:24], sel 4'b1000; 0: offset 00 maps to lane [7:0], sel 4'b0001
- TIMEOUT, 255, maximum REQ cycles without ack before bus error (≥ 1)

- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  1  EX/MEM holds a valid instruction
- aluop_i  in  `AluOpBus  operation (`EXE_LB/LBU/LH/LHU/LW/LL/SB/SH/SW/SC_OP`; all others are non-memory)
- mem_addr_i  in  ADDR_W  effective address
- reg2_i  in  32  store data
- wd_i / wreg_i / wdata_i  in  5/1/32  destination, write enable, ALU result
- flush_i  in  1  pipeline flush (exception/eret)
- llbit_clr_i  in  1  clear link state (eret)
- wd_o / wreg_o / wdata_o  out  5/1/32  to MEM/WB
- done_o  out  1  wd_o/wreg_o/wdata_o valid this cycle
- stallreq_o  out  1  stall request to ctrl
- excp_adel_o / excp_ades_o  out  1  load / store address error
- bus_err_o  out  1  timeout occurred
- bad_addr_o  out  ADDR_W  faulting address
- bus_req_o / bus_we_o  out  1  request, write
- bus_addr_o  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- bus_sel_o  out  4  byte enables
- bus_wdata_o  out  32  store data, replicated into all lanes for SB/SH
- bus_ack_i  in  1  transfer complete, bus_rdata_i valid
- bus_rdata_i  in  32  read data

## Operation
- States: IDLE, REQ, DONE.
- Reset: all outputs and registers 0, state IDLE, link bit 0.
- IDLE, non-memory op: wd/wreg/wdata pass through combinationally; done_o = req_valid_i; stallreq_o = 0.
- IDLE, memory op with req_valid_i: latch op, address, data, and wd. stallreq_o = 1 combinationally.
  - Misaligned access (H: addr[0] ≠ 0; W/LL/SC: addr[1:0] ≠ 0): go to DONE with no bus request. Set excp_adel_o (load) or excp_ades_o (store), bad_addr_o = addr, wreg_o = 0.
  - Otherwise: go to REQ and clear the timeout counter.
- REQ: bus_req_o = 1; address, sel, we, and wdata held stable; stallreq_o = 1.
  - On bus_ack_i: capture the steered/extended load result, go to DONE.
  - On counter reaching TIMEOUT: drop the request, go to DONE with bus_err_o = 1 and wreg_o = 0.
- DONE: done_o = 1 for exactly one cycle, stallreq_o = 0, registered results valid; go to IDLE.
- Load data: LB/LH sign-extend; LBU/LHU zero-extend. Lane selection follows BIG_ENDIAN, mirrored for the little-endian setting.
- flush_i (any state) has priority:
  - Next state IDLE; no done_o.
  - bus_req_o forced to 0 in the same cycle.
  - An ack arriving in the same cycle is discarded.
- bus_ack_i outside REQ is ignored.

## Timing
- Aligned access with ack in the first REQ cycle: accept at cycle 0, REQ at 1, DONE at 2. stallreq_o is high in cycles 0–1.
- Each wait state adds one cycle. Timeout: DONE at cycle TIMEOUT+1.
- Misaligned access: DONE at cycle 1.
- Back-to-back memory operations: the next accept occurs no earlier than the cycle after DONE.
- Reset asserted mid-REQ: bus_req_o drops immediately (asynchronous).

## Configuration
- MEM_LLSC_EN defined:
  - LL sets the link bit and records link address addr[ADDR_W-1:2] on ack.
  - SC performs the store only if the link bit is set and the address matches. On success it returns wdata_o = 1 and clears the link bit. On failure it returns 0 with no bus request (DONE at cycle 1).
  - llbit_clr_i, flush_i, and any SW/SH/SB to the linked word clear the link bit.
- MEM_LLSC_EN undefined: LL behaves as LW; SC behaves as SW and always returns 1; no link state exists.

## Test plan
- LB at 0x103 with rdata 0x000000F0, BIG_ENDIAN = 1, ack after 2 wait states -> sel 0001, wdata_o 0xFFFFFFF0, done_o at cycle 4.
- SH of 0x1234ABCD at 0x202, BIG_ENDIAN = 0 -> bus_sel_o 1100, bus_wdata_o 0xABCDABCD, bus_we_o 1.
- LW at 0x101 -> excp_adel_o = 1, bad_addr_o 0x101, no bus_req_o, done at cycle 1.
- No ack, TIMEOUT = 4 -> bus_req_o high for 4 cycles, bus_err_o = 1, wreg_o = 0.
- MEM_LLSC_EN: LL 0x40, SC 0x40 -> store issued, wdata_o 1; repeated SC -> wdata_o 0, no request.
- flush_i during REQ with simultaneous ack -> bus_req_o 0 that cycle, no done_o, IDLE next cycle.
